// File: rtl/popcnt_accum_ctrl.sv
// popcnt_accum_ctrl
// Time-shares one 9-to-4 popcount compressor across a stream of 3x3 binary
// windows, accumulating a programmed number of window popcounts into one
// saturating partial sum. Valid/ready handshakes on the input and output sides.

module popcnt_accum_ctrl #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [3:0]       pop_q;
  logic             pop_v;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic             accept;
  logic [3:0]       pop_d;
  logic [ACC_W:0]   acc_sum;

  // 9-to-4 compressor: number of set bits in one window.
  function automatic logic [3:0] compress9(input logic [8:0] w);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 9; i++) begin
      s = s + {3'b000, w[i]};
    end
    return s;
  endfunction

  // Beat handshake, compressor output and one-bit-wider sum for saturation detect.
  assign accept  = in_valid & in_ready & (state == RUN);
  assign pop_d   = compress9(in_data);
  assign acc_sum = {1'b0, acc} + {{(ACC_W-3){1'b0}}, pop_q};

  assign out_sum = acc;
  assign out_ovf = ovf;

  // Control FSM, compressor pipeline register and saturating accumulator.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking '=' would let later statements see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      pop_q     <= '0;
      pop_v     <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clr) begin
      // NOTE: clr is a synchronous abort, distinct from the asynchronous rst_n;
      // it beats start, beats and the output handshake in every state.
      state     <= IDLE;
      rem       <= '0;
      pop_q     <= '0;
      pop_v     <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Compressor stage: a bubble clears pop_v so nothing is added next cycle.
      pop_v <= accept;
      if (accept) begin
        pop_q <= pop_d;
      end

      // Accumulate stage runs in every state whenever a popcount is pending.
      if (pop_v) begin
        if (acc_sum[ACC_W]) begin
          acc <= '1;
          ovf <= 1'b1;
        end else begin
          acc <= acc_sum[ACC_W-1:0];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            rem      <= (cfg_len == '0) ? CNT_W'(1) : cfg_len;
            acc      <= '0;
            ovf      <= 1'b0;
            pop_v    <= 1'b0;
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            rem <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The last popcount is folded into acc on this edge.
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
